// File: rtl/imem_uart_loader.sv
// Boots instruction memory from a UART frame (A5, N lo/hi, N LE words[, XOR checksum if LOADER_CHECKSUM_EN]).
// Latency: one imem write the cycle after each word's last stop sample; done/error are sticky.
// No backpressure: the serial line cannot be stalled, so every received byte is consumed or ignored.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0]   MAX_WORDS = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE, ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CHK;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    logic          rx_s1, rx_s2, rx_d;
    logic          rx_busy;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_shift;
    logic          byte_vld, frame_err;

    state_t                state, state_nx;
    logic [7:0]            len_lo;
    logic [15:0]           n_len, words_left;
    logic [1:0]            byte_idx;
    logic [23:0]           wbuf;
    logic [ADDR_WIDTH-1:0] addr_ptr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk_x;
`endif

    assign n_len = {rx_shift, len_lo};

    // rx_bit 0 is the start bit (checked at half period), 1..8 data, 9 stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
            rx_busy   <= 1'b0;
            rx_bit    <= 4'd0;
            rx_cnt    <= '0;
            rx_shift  <= 8'd0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= uart_rx;
            rx_s2     <= rx_s1;
            rx_d      <= rx_s2;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_busy) begin
                if (rx_d && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= 4'd0;
                    rx_cnt  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end else if (rx_cnt != BIT_END) begin
                rx_cnt <= rx_cnt + CW'(1);
            end else begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_busy   <= 1'b0;
                    byte_vld  <= 1'b1;
                    frame_err <= !rx_s2;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (byte_vld && frame_err && state != DONE && state != ERR) begin
            state_nx = ERR;
        end else if (byte_vld) begin
            case (state)
                IDLE:   if (rx_shift == 8'hA5) state_nx = LEN_LO;
                LEN_LO: state_nx = LEN_HI;
                LEN_HI: begin
                    if ({17'd0, n_len} > MAX_WORDS) state_nx = ERR;
                    else if (n_len == 16'd0)        state_nx = PAYLOAD_END;
                    else                            state_nx = DATA;
                end
                DATA:   if (byte_idx == 2'd3 && words_left == 16'd1) state_nx = PAYLOAD_END;
`ifdef LOADER_CHECKSUM_EN
                CHK:    state_nx = (rx_shift == chk_x) ? DONE : ERR;
`endif
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        cpu_hold = (state != DONE);
        done     = (state == DONE);
        error    = (state == ERR);
    end

    // Bytes accumulate LSB-first in wbuf; the 4th byte completes the word directly into imem_wdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo     <= 8'd0;
            words_left <= 16'd0;
            byte_idx   <= 2'd0;
            wbuf       <= 24'd0;
            addr_ptr   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_x      <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (byte_vld && !frame_err) begin
                case (state)
                    LEN_LO: len_lo <= rx_shift;
                    LEN_HI: begin
                        words_left <= n_len;
                        byte_idx   <= 2'd0;
                        addr_ptr   <= '0;
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_x    <= chk_x ^ rx_shift;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_shift, wbuf};
                            imem_addr  <= addr_ptr;
                            addr_ptr   <= addr_ptr + ADDR_WIDTH'(1);
                            words_left <= words_left - 16'd1;
                        end else begin
                            wbuf <= {rx_shift, wbuf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized frame bench for imem_uart_loader; expectations come from a frame-parsing reference model.
module tb_imem_uart_loader;
    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          imem_we, cpu_hold, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]    tx[$];
    logic [AW-1:0] cap_addr[$], exp_addr[$];
    logic [31:0]   cap_data[$], exp_data[$];
    logic          exp_done, exp_err;
    logic          mon_on = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Captures writes, checks write outputs hold between strobes and cpu_hold is the inverse of done.
    always @(negedge clk) begin
        if (mon_on) begin
            if (imem_we) begin
                cap_addr.push_back(imem_addr);
                cap_data.push_back(imem_wdata);
            end else if (!rst) begin
                vectors++;
                if (imem_addr !== last_addr || imem_wdata !== last_data) begin
                    miscompares++;
                    $display("FAIL hold: addr/data %0h/%08h changed from %0h/%08h without imem_we",
                             imem_addr, imem_wdata, last_addr, last_data);
                end
            end
            vectors++;
            if (cpu_hold !== !done) begin
                miscompares++;
                $display("FAIL cpu_hold: got %b with done=%b, required %b", cpu_hold, done, !done);
            end
        end
        last_addr = imem_addr;
        last_data = imem_wdata;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // A byte sent with a bad stop bit leaves the loader in its final state right away.
    task automatic send_frame(input int bad, input int count);
        for (int i = 0; i < count; i++) begin
            send_byte(tx[i], (i == bad) ? 1'b0 : 1'b1);
            if (i == bad) begin
                repeat (2) @(negedge clk);
                vectors++;
                if (error !== exp_err) begin
                    miscompares++;
                    $display("FAIL stop_err_timing: error=%b required %b", error, exp_err);
                end
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cap_addr.delete();
        cap_data.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic build(input int junk, input int n);
        logic [7:0] b;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'd0;
`endif
        tx.delete();
        repeat (junk) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            tx.push_back(b);
        end
        tx.push_back(8'hA5);
        tx.push_back(8'(n));
        tx.push_back(8'(n >> 8));
        repeat (4 * n) begin
            b = 8'($urandom);
            tx.push_back(b);
`ifdef LOADER_CHECKSUM_EN
            x ^= b;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(x);
`endif
    endtask

    task automatic load_reference(input logic prefix);
        tx.delete();
        if (prefix) tx = '{8'h00, 8'hFF, 8'h5A};
        foreach (tx[i]) ;
        tx.push_back(8'hA5); tx.push_back(8'h02); tx.push_back(8'h00);
        tx.push_back(8'h13); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h00);
        tx.push_back(8'h93); tx.push_back(8'h00); tx.push_back(8'h10); tx.push_back(8'h00);
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(8'h90);
`endif
    endtask

    // Reference model: locate sync, read N, slice complete words, then judge the trailer.
    task automatic model(input int bad);
        int lim, p, n, w, base;
        logic pending;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'd0;
`endif
        lim = (bad >= 0) ? bad : tx.size();
        exp_addr.delete(); exp_data.delete();
        exp_done = 1'b0; exp_err = 1'b0; pending = 1'b1; p = -1; w = 0;
        for (int i = 0; i < lim; i++) if (p < 0 && tx[i] == 8'hA5) p = i;
        if (p >= 0 && p + 2 < lim) begin
            n = int'({tx[p+2], tx[p+1]});
            if (n > (1 << AW)) begin
                exp_err = 1'b1;
                pending = 1'b0;
            end else begin
                while (w < n && p + 6 + 4 * w < lim) begin
                    base = p + 3 + 4 * w;
                    exp_addr.push_back(AW'(w));
                    exp_data.push_back({tx[base+3], tx[base+2], tx[base+1], tx[base]});
`ifdef LOADER_CHECKSUM_EN
                    x ^= tx[base] ^ tx[base+1] ^ tx[base+2] ^ tx[base+3];
`endif
                    w++;
                end
                if (w == n) begin
`ifdef LOADER_CHECKSUM_EN
                    if (p + 3 + 4 * n < lim) begin
                        pending = 1'b0;
                        if (tx[p+3+4*n] == x) exp_done = 1'b1;
                        else                  exp_err  = 1'b1;
                    end
`else
                    pending  = 1'b0;
                    exp_done = 1'b1;
`endif
                end
            end
        end
        if (pending && bad >= 0) exp_err = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, error} !== {1'b0, AW'(0), 32'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: we=%b addr=%0h wdata=%08h hold=%b done=%b err=%b, required 0 0 0 1 0 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
        end
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reference_frames();
        int bad;
        int ncase;
`ifdef LOADER_CHECKSUM_EN
        ncase = 4;
`else
        ncase = 3;
`endif
        for (int c = 0; c < ncase; c++) begin
            load_reference(c == 1);
            if (c == 3) tx[tx.size()-1] = 8'h81;
            bad = (c == 2) ? 5 : -1;
            do_reset();
            model(bad);
            send_frame(bad, tx.size());
            repeat (4) @(negedge clk);
            vectors++;
            if (cap_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL ref%0d_count: %0d writes, required %0d", c, cap_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
                vectors++;
                if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL ref%0d_write%0d: %0h/%08h, required %0h/%08h",
                             c, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
                end
            end
            vectors++;
            if ({done, error, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
                miscompares++;
                $display("FAIL ref%0d_status: done/err/hold=%b%b%b, required %b%b%b",
                         c, done, error, cpu_hold, exp_done, exp_err, !exp_done);
            end
        end
    endtask

    task automatic test_random_frames();
        int bad;
        for (int k = 0; k < 8; k++) begin
            build($urandom_range(0, 3), $urandom_range(1, 5));
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(0, 2) == 0) tx[tx.size()-1] ^= 8'($urandom_range(1, 255));
`endif
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tx.size() - 1)) : -1;
            do_reset();
            model(bad);
            send_frame(bad, tx.size());
            repeat (4) @(negedge clk);
            vectors++;
            if (cap_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL rnd%0d_count: %0d writes, required %0d", k, cap_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
                vectors++;
                if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_write%0d: %0h/%08h, required %0h/%08h",
                             k, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
                end
            end
            vectors++;
            if ({done, error} !== {exp_done, exp_err}) begin
                miscompares++;
                $display("FAIL rnd%0d_status: done/err=%b%b, required %b%b", k, done, error, exp_done, exp_err);
            end
        end
    endtask

    task automatic test_length_boundaries();
        int lens[3] = '{0, 1 << AW, (1 << AW) + 1};
        for (int c = 0; c < 3; c++) begin
            build($urandom_range(0, 2), lens[c]);
            if (c == 2) while (tx.size() > 8) void'(tx.pop_back());
            do_reset();
            model(-1);
            send_frame(-1, tx.size());
            repeat (4) @(negedge clk);
            vectors++;
            if (cap_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL len%0d_count: %0d writes, required %0d", lens[c], cap_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
                vectors++;
                if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL len%0d_write%0d: %0h/%08h, required %0h/%08h",
                             lens[c], i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
                end
            end
            vectors++;
            if ({done, error, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
                miscompares++;
                $display("FAIL len%0d_status: done/err/hold=%b%b%b, required %b%b%b",
                         lens[c], done, error, cpu_hold, exp_done, exp_err, !exp_done);
            end
        end
    endtask

    task automatic test_reset_midframe();
        load_reference(1'b0);
        do_reset();
        send_frame(-1, 9);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, error} !== {1'b0, AW'(0), 32'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_state: we=%b addr=%0h wdata=%08h hold=%b done=%b err=%b, required 0 0 0 1 0 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
        end
        vectors++;
        if (cap_addr.size() != 1) begin
            miscompares++;
            $display("FAIL midrst_partial: %0d writes before reset, required 1", cap_addr.size());
        end
        rst = 1'b0;
        cap_addr.delete();
        cap_data.delete();
        repeat (2) @(negedge clk);
        model(-1);
        send_frame(-1, tx.size());
        repeat (4) @(negedge clk);
        vectors++;
        if (cap_addr.size() != 2 || cap_addr[0] !== AW'(0) || cap_data[0] !== 32'h00000013 ||
            cap_addr[1] !== AW'(1) || cap_data[1] !== 32'h00100093) begin
            miscompares++;
            $display("FAIL midrst_reload: %0d writes, first addr %0h, required 2 writes from addr 0",
                     cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : AW'(0));
        end
        vectors++;
        if ({done, error} !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_status: done/err=%b%b, required 10", done, error);
        end
    endtask

    task automatic test_glitch();
        load_reference(1'b0);
        do_reset();
        model(-1);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        send_frame(-1, tx.size());
        repeat (4) @(negedge clk);
        vectors++;
        if (cap_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL glitch_count: %0d writes, required %0d", cap_addr.size(), exp_addr.size());
        end
        vectors++;
        if ({done, error} !== {exp_done, exp_err}) begin
            miscompares++;
            $display("FAIL glitch_status: done/err=%b%b, required %b%b", done, error, exp_done, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_reference_frames();
        test_random_frames();
        test_length_boundaries();
        test_reset_midframe();
        test_glitch();
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
